mem_responder: RTL and testbench

Memory-side responder for the CPU's Start/rnw/Ready handshake. It accepts one word transaction per Start pulse from the control logic and holds an internal word-addressed memory. After a programmable number of wait states it performs the read or write and returns a one-cycle Ready. The CPU stalls its sequence counter while Ready is low. A side-band load port lets the bench or a boot loader fill memory while the responder is idle.

---
 rtl/mem_responder_pkg.sv | 14 +
 rtl/mem_responder_mem_array.sv | 35 +++
 rtl/mem_responder.sv | 146 ++++++++++++++
 tb/tb_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared state enum and default widths for the memory responder
// Reused by the CPU control path, so keep the names stable.
package mem_responder_pkg;

  localparam int ADDR_W = 16;  // default word-address width (AR)
  localparam int DATA_W = 16;  // default data width (DR/bus)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// rtl/mem_responder_mem_array.sv - DEPTH x WIDTH word memory, one write port, registered read
// Ports:
//   clk            rising-edge clock
//   we/waddr/wdata single write port (caller muxes transaction write and load port)
//   re/raddr       read strobe and address; rdata updates on the edge re is high
//   rdata          registered read data, held while re is low
// The array and the read register carry no reset.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = DATA_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - Start/rnw/Ready memory responder with programmable wait states
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   start, rnw, addr, wdata   one-cycle request, sampled together
//   rdata                     read data, held until the next read completes
//   ready, err                one-cycle completion pulse; err flags addr >= DEPTH
//   busy                      high while the request is waiting
//   ld_en, ld_addr, ld_data   side-band load port, honoured only when idle
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W  = mem_responder_pkg::ADDR_W,
  parameter int DATA_W  = mem_responder_pkg::DATA_W,
  parameter int DEPTH   = 1024,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int MEM_AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  mem_state_t        state;
  logic [3:0]        cnt;
  logic              rnw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ready_q;
  logic              err_q;
  logic              busy_q;
  logic              rd_hold;  // 1: last completed read was in range, rdata comes from the array

  logic              accept;
  logic              enter_done;
  logic [3:0]        start_cnt;
  logic              acc_rnw;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_inr;
  logic              ld_ok;
  logic              mem_we;
  logic              mem_re;
  logic [MEM_AW-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign accept    = start && (state == IDLE || state == DONE);
  assign start_cnt = rnw ? 4'(RD_WAIT) : 4'(WR_WAIT);

  // The access on the edge entering DONE uses the live request when it
  // completes with zero wait states, otherwise the latched one.
  assign acc_rnw   = accept ? rnw   : rnw_q;
  assign acc_addr  = accept ? addr  : addr_q;
  assign acc_wdata = accept ? wdata : wdata_q;
  assign acc_inr   = {1'b0, acc_addr} < LIMIT;

  assign enter_done = (accept && start_cnt == 4'd0) || (state == WAIT && cnt == 4'd1);

  assign ld_ok = ld_en && !start && state == IDLE && ({1'b0, ld_addr} < LIMIT);

  // ld_ok needs IDLE without start, a transaction write needs start or WAIT:
  // the two write sources never coincide.
  assign mem_we    = (enter_done && !acc_rnw && acc_inr) || ld_ok;
  assign mem_re    = enter_done && acc_rnw && acc_inr;
  assign mem_waddr = ld_ok ? ld_addr[MEM_AW-1:0] : acc_addr[MEM_AW-1:0];
  assign mem_wdata = ld_ok ? ld_data : acc_wdata;

  mem_array #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W),
    .AW    (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (acc_addr[MEM_AW-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_hold <= 1'b0;
    end else begin
      ready_q <= enter_done;
      err_q   <= enter_done && !acc_inr;
      if (enter_done && acc_rnw) begin
        rd_hold <= acc_inr;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rnw_q   <= rnw;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= start_cnt;
            state   <= (start_cnt == 4'd0) ? DONE : WAIT;
            busy_q  <= (start_cnt != 4'd0);
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= DONE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign rdata = rd_hold ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (wait-state and zero-wait instances)
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        rnw = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic        ld_en0 = 1'b0, ld_en1 = 1'b0;
  logic [15:0] ld_addr = '0, ld_data = '0;
  logic [15:0] rdata0, rdata1;
  logic        ready0, ready1, err0, err1, busy0, busy1;

  int checks = 0;
  int failures = 0;

  logic [15:0] m [2][1024];
  logic [15:0] last_rd [2];

  typedef struct {
    bit          gap;
    bit          r;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  mem_responder #(.RD_WAIT(2), .WR_WAIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .rnw(rnw), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0),
    .ld_en(ld_en0), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  mem_responder #(.RD_WAIT(0), .WR_WAIT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rnw(rnw), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .ready(ready1), .err(err1), .busy(busy1),
    .ld_en(ld_en1), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One transaction; returns in the ready cycle so a caller may start the next one back-to-back.
  task automatic txn(input int inst, input bit r, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] exp_rd, input bit exp_err);
    int wt, lat, nbusy;
    logic rdy, bsy;
    wt = (inst == 1) ? 0 : (r ? 2 : 1);
    rnw = r; addr = a; wdata = d;
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    lat = 1; nbusy = 0;
    rdy = (inst == 1) ? ready1 : ready0;
    bsy = (inst == 1) ? busy1 : busy0;
    while (!rdy && lat <= 20) begin
      if (bsy) nbusy++;
      @(posedge clk); #1;
      lat++;
      rdy = (inst == 1) ? ready1 : ready0;
      bsy = (inst == 1) ? busy1 : busy0;
    end
    check($sformatf("latency i%0d a=%h", inst, a), lat, wt + 1);
    check($sformatf("busy_cycles i%0d a=%h", inst, a), nbusy, wt);
    check($sformatf("busy_in_done i%0d", inst), {31'd0, bsy}, 0);
    check($sformatf("err i%0d a=%h", inst, a), {31'd0, (inst == 1) ? err1 : err0}, {31'd0, exp_err});
    check($sformatf("rdata i%0d a=%h", inst, a), {16'd0, (inst == 1) ? rdata1 : rdata0}, {16'd0, exp_rd});
  endtask

  task automatic model_apply(input int inst, input bit r, input logic [15:0] a, input logic [15:0] d);
    if (!r && a < 16'd1024) m[inst][a[9:0]] = d;
    if (r) last_rd[inst] = (a < 16'd1024) ? m[inst][a[9:0]] : 16'h0000;
  endtask

  task automatic mtxn(input int inst, input bit r, input logic [15:0] a, input logic [15:0] d);
    model_apply(inst, r, a, d);
    txn(inst, r, a, d, last_rd[inst], a >= 16'd1024);
  endtask

  // Idle cycle; a completed transaction must not stretch its ready pulse.
  task automatic gap();
    @(posedge clk); #1;
    check("ready_width", {30'd0, ready0, ready1}, 0);
  endtask

  task automatic load(input bit both, input logic [15:0] a, input logic [15:0] d);
    ld_en0 = 1'b1; ld_en1 = both; ld_addr = a; ld_data = d;
    m[0][a[9:0]] = d;
    if (both) m[1][a[9:0]] = d;
    @(posedge clk); #1;
    ld_en0 = 1'b0; ld_en1 = 1'b0;
  endtask

  initial begin
    int nr;
    logic [15:0] got, val;
    bit r;
    int inst;
    logic [15:0] a, d;

    tbl[0] = '{0, 1, 16'h03FF, 16'h0000, 16'h3FF3, 0};
    tbl[1] = '{1, 1, 16'h0005, 16'h0000, 16'hBEEF, 0};
    tbl[2] = '{1, 0, 16'h0007, 16'h1234, 16'hBEEF, 0};
    tbl[3] = '{0, 1, 16'h0007, 16'h0000, 16'h1234, 0};
    tbl[4] = '{1, 0, 16'h0400, 16'hDEAD, 16'h1234, 1};
    tbl[5] = '{0, 1, 16'h0400, 16'h0000, 16'h0000, 1};
    tbl[6] = '{1, 1, 16'h0000, 16'h0000, 16'hA5A5, 0};
    tbl[7] = '{0, 0, 16'h03FF, 16'h0F0F, 16'hA5A5, 0};
    tbl[8] = '{0, 1, 16'h03FF, 16'h0000, 16'h0F0F, 0};
    tbl[9] = '{1, 1, 16'h03FF, 16'h0000, 16'h0F0F, 0};
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_outputs0", {ready0, err0, busy0, rdata0}, 0);
    check("reset_outputs1", {ready1, err1, busy1, rdata1}, 0);

    for (int i = 0; i < 64; i++) load(1, 16'(i), 16'hA5A5 ^ 16'(i * 16'h0101));
    load(1, 16'h0005, 16'hBEEF);
    load(1, 16'h03FF, 16'h3FF3);

    // Table: first row starts in the cycle right after the last load.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].gap) gap();
      model_apply(0, tbl[i].r, tbl[i].a, tbl[i].d);
      txn(0, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].exp_rd, tbl[i].exp_err);
    end

    // start and load-port strobe during WAIT are both ignored.
    gap();
    rnw = 1'b1; addr = 16'h0005; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b1; rnw = 1'b0; addr = 16'h0007; wdata = 16'h9999;
    ld_en0 = 1'b1; ld_addr = 16'h0005; ld_data = 16'h5555;
    nr = 0; got = 16'h0000;
    for (int k = 0; k < 7; k++) begin
      if (ready0) begin nr++; got = rdata0; end
      @(posedge clk); #1;
      start0 = 1'b0; ld_en0 = 1'b0;
    end
    check("wait_start_ready_count", nr, 1);
    check("wait_start_rdata", {16'd0, got}, {16'd0, 16'hBEEF});
    mtxn(0, 1, 16'h0005, 16'h0000);
    gap();
    mtxn(0, 1, 16'h0007, 16'h0000);

    // Zero-wait instance: back-to-back reads in each DONE cycle, then write then read.
    gap();
    mtxn(1, 1, 16'h0001, 16'h0000);
    mtxn(1, 1, 16'h0002, 16'h0000);
    mtxn(1, 1, 16'h0003, 16'h0000);
    gap();
    mtxn(1, 1, 16'h0001, 16'h0000);
    gap();
    mtxn(1, 0, 16'h0009, 16'h7777);
    mtxn(1, 1, 16'h0009, 16'h0000);
    mtxn(1, 0, 16'h0400, 16'h1111);
    mtxn(1, 1, 16'h0400, 16'h0000);
    gap();

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      inst = int'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 16'(1024 + $urandom_range(0, 64511));
      else a = 16'($urandom_range(0, 63));
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) gap();
      mtxn(inst, r, a, d);
    end

    // Asynchronous reset in the middle of a read's WAIT.
    gap();
    mtxn(0, 1, 16'h0005, 16'h0000);
    val = last_rd[0];
    gap();
    rnw = 1'b1; addr = 16'h0005; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    check("busy_before_reset", {31'd0, busy0}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {ready0, busy0, err0, rdata0}, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    @(posedge clk); #1;
    check("post_reset_idle", {ready0, busy0, rdata0}, 0);
    model_apply(0, 1, 16'h0005, 16'h0000);
    txn(0, 1, 16'h0005, 16'h0000, val, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
